// File: rtl/servant_ram_arb_if.sv
// servant_ram_arb_if: one Wishbone-classic port (master drives request, slave returns ack/rdt).
// Latency: none, this is a signal bundle only.
// Backpressure: the master holds cyc until it sees ack; the slave acks once per accepted access.
interface servant_ram_arb_if #(
  parameter int adr_w = 6,
  parameter int dw    = 32
);
  logic [adr_w-1:0] adr;
  logic [dw-1:0]    dat;
  logic [dw/8-1:0]  sel;
  logic             we;
  logic             cyc;
  logic             ack;
  logic [dw-1:0]    rdt;

  modport master (output adr, dat, sel, we, cyc, input ack, rdt);
  modport slave  (input adr, dat, sel, we, cyc, output ack, rdt);
endinterface

// File: rtl/servant_ram_arb.sv
// servant_ram_arb: two Wishbone-classic slave ports sharing one byte-enabled single-port RAM.
// Latency: ack appears rd_lat cycles after the accepting edge; one access per rd_lat+1 cycles.
// Backpressure: requests are sampled only in IDLE; the losing port simply keeps cyc high and waits.
// Optional feature macro: SERVANT_RAM_PARITY_EN (per-byte even parity, drives o_par_err).
module servant_ram_arb #(
  parameter int depth   = 256,
  parameter int dw      = 32,
  parameter int aw      = $clog2(depth),
  parameter     memfile = "",
  parameter int rd_lat  = 1,
  parameter int rr      = 1
) (
  input  logic             i_wb_clk,
  input  logic             i_rst_n,
  servant_ram_arb_if.slave wb0,
  servant_ram_arb_if.slave wb1,
  output logic             o_par_err
);
  localparam int nb    = dw / 8;
  localparam int ww    = aw - $clog2(nb);
  localparam int words = 1 << ww;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [dw-1:0] rdt_q, rdt_d;
  logic [dw-1:0] stage_q;
  logic [dw-1:0] mem_q [words];

  logic          win;
  logic          acc;
  logic [ww-1:0] m_adr;
  logic [dw-1:0] m_dat;
  logic [nb-1:0] m_sel;
  logic          m_we;

  // Pick the winner and steer its request onto the RAM; acc marks the accepting edge.
  always_comb begin
    win = 1'b0;
    if (wb0.cyc && wb1.cyc) begin
      win = (rr != 0) ? ~last_q : 1'b0;
    end else begin
      win = ~wb0.cyc;
    end
    acc   = i_rst_n && (state_q == IDLE) && (wb0.cyc || wb1.cyc);
    m_adr = win ? wb1.adr : wb0.adr;
    m_dat = win ? wb1.dat : wb0.dat;
    m_sel = win ? wb1.sel : wb0.sel;
    m_we  = win ? wb1.we  : wb0.we;
  end

  // Next state, grant and round-robin pointer; the pointer follows every grant.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          gnt_d   = win;
          last_d  = win;
          state_d = (rd_lat == 2) ? WAIT : ACK;
        end
      end
      WAIT:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared read register: loads at accept (rd_lat 1) or in WAIT (rd_lat 2), holds otherwise.
  always_comb begin
    rdt_d = rdt_q;
    if (rd_lat == 1) begin
      if (acc) rdt_d = mem_q[m_adr];
    end else if (state_q == WAIT) begin
      rdt_d = stage_q;
    end
  end

  // Control registers; last starts at 1 so port 0 takes the first tie after reset.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rdt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rdt_q   <= rdt_d;
    end
  end

  // RAM array: read-before-write, byte-enabled write at the accepting edge, never reset.
  always_ff @(posedge i_wb_clk) begin
    if (acc) begin
      stage_q <= mem_q[m_adr];
      if (m_we) begin
        for (int b = 0; b < nb; b++) begin
          if (m_sel[b]) mem_q[m_adr][8*b +: 8] <= m_dat[8*b +: 8];
        end
      end
    end
  end

  assign wb0.ack = (state_q == ACK) && !gnt_q;
  assign wb1.ack = (state_q == ACK) &&  gnt_q;
  assign wb0.rdt = rdt_q;
  assign wb1.rdt = rdt_q;

`ifdef SERVANT_RAM_PARITY_EN
  logic [nb-1:0] par_q [words];
  logic [nb-1:0] pchk_q;
  logic          rd_acc_q;
  logic [nb-1:0] par_now;

  // RAM image and its parity: zeroed contents.
  initial begin
    for (int i = 0; i < words; i++) mem_q[i] = '0;
    for (int i = 0; i < words; i++)
      for (int b = 0; b < nb; b++) par_q[i][b] = ^mem_q[i][8*b +: 8];
  end

  // Parity side array tracks every enabled byte write.
  always_ff @(posedge i_wb_clk) begin
    if (acc && m_we) begin
      for (int b = 0; b < nb; b++) begin
        if (m_sel[b]) par_q[m_adr][b] <= ^m_dat[8*b +: 8];
      end
    end
  end

  // Remember stored parity of the accessed word and whether it was a read.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pchk_q   <= '0;
      rd_acc_q <= 1'b0;
    end else if (acc) begin
      pchk_q   <= par_q[m_adr];
      rd_acc_q <= !m_we;
    end
  end

  // Recompute parity over the returned word during the ack cycle.
  always_comb begin
    par_now = '0;
    for (int b = 0; b < nb; b++) par_now[b] = ^rdt_q[8*b +: 8];
  end

  assign o_par_err = (state_q == ACK) && rd_acc_q && (par_now != pchk_q);
`else
  assign o_par_err = 1'b0;
`endif
endmodule
